// File: rtl/alu_sequencer_if.sv
// Instruction-fetch and ALU-control bundle between the sequencer and its memory/ALU.
// The master side drives fetch requests and ALU controls; the slave side returns data and results.
interface alu_sequencer_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_carry_in;
    logic        alu_is_shift;
    logic [1:0]  alu_scode;
    logic [2:0]  alu_acode;
    logic [7:0]  alu_r;
    logic        alu_zero;
    logic        alu_carry_out;

    modport master (
        output imem_req, imem_addr, alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode,
        input  imem_ack, imem_data, alu_r, alu_zero, alu_carry_out
    );

    modport slave (
        input  imem_req, imem_addr, alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode,
        output imem_ack, imem_data, alu_r, alu_zero, alu_carry_out
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the 8-bit ALU datapath with an 8x8 register file.
// 3 cycles per instruction with zero-wait memory; FETCH holds req/addr stable until imem_ack.
module alu_sequencer #(
    parameter logic [7:0] RESET_PC        = 8'h00,
    parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.master       bus,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  halted,
    output logic                  illegal,
    input  logic [2:0]            dbg_sel,
    output logic [7:0]            dbg_data
);
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  rf_q [8];
    logic [7:0]  rf_d [8];
    logic        z_q, z_d, c_q, c_d, illegal_q, illegal_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic        cin_q, cin_d, is_shift_q, is_shift_d;
    logic [1:0]  scode_q, scode_d;
    logic [2:0]  acode_q, acode_d;

    logic [3:0] op;
    logic [2:0] rd, rs, rt, imm3;
    logic [7:0] imm8;
    logic       op_alu, op_shift, op_li, op_jz, op_jc, op_halt, op_ill;

    assign op   = ir_q[15:12];
    assign rd   = ir_q[11:9];
    assign rs   = ir_q[8:6];
    assign rt   = ir_q[5:3];
    assign imm3 = ir_q[2:0];
    assign imm8 = ir_q[7:0];

    assign op_alu   = (op[3] == 1'b0) && (op[2:0] != 3'b111);
    assign op_ill   = (op == 4'b0111);
    assign op_shift = (op[3:2] == 2'b10);
    assign op_li    = (op == 4'b1100);
    assign op_jz    = (op == 4'b1101);
    assign op_jc    = (op == 4'b1110);
    assign op_halt  = (op == 4'b1111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            illegal_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            is_shift_q <= 1'b0;
            scode_q    <= '0;
            acode_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            rf_q       <= rf_d;
            z_q        <= z_d;
            c_q        <= c_d;
            illegal_q  <= illegal_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            is_shift_q <= is_shift_d;
            scode_q    <= scode_d;
            acode_q    <= acode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        rf_d       = rf_q;
        z_d        = z_q;
        c_d        = c_q;
        illegal_d  = illegal_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        is_shift_d = is_shift_q;
        scode_d    = scode_q;
        acode_d    = acode_q;
        unique case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU controls are frozen here so the external ALU settles during EXEC
                a_d        = '0;
                b_d        = '0;
                cin_d      = 1'b0;
                is_shift_d = 1'b0;
                scode_d    = '0;
                acode_d    = '0;
                if (op_alu) begin
                    a_d     = rf_q[rs];
                    b_d     = rf_q[rt];
                    acode_d = op[2:0];
                    cin_d   = c_q;
                end else if (op_shift) begin
                    a_d        = rf_q[rs];
                    b_d        = {5'b0, imm3};
                    scode_d    = op[1:0];
                    is_shift_d = 1'b1;
                    cin_d      = c_q;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH;
                if (op_alu || op_shift) begin
                    if (rd != 3'd0) rf_d[rd] = bus.alu_r;
                    z_d = bus.alu_zero;
                    // Logic ops and zero-amount shifts have no meaningful carry
                    if ((op_alu && !op[2]) || (op_shift && imm3 != 3'd0)) c_d = bus.alu_carry_out;
                end else if (op_li) begin
                    if (rd != 3'd0) rf_d[rd] = imm8;
                end else if (op_jz) begin
                    if (z_q) pc_d = imm8;
                end else if (op_jc) begin
                    if (c_q) pc_d = imm8;
                end else if (op_halt) begin
                    state_d = S_HALT;
                end else if (op_ill) begin
                    illegal_d = 1'b1;
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                end
            end
            default: ;
        endcase
        rf_d[0] = '0;
    end

    always_comb begin
        // Gated by rst_n so no request is seen while reset is asserted
        bus.imem_req     = (state_q == S_FETCH) && rst_n;
        bus.imem_addr    = pc_q;
        bus.alu_a        = a_q;
        bus.alu_b        = b_q;
        bus.alu_carry_in = cin_q;
        bus.alu_is_shift = is_shift_q;
        bus.alu_scode    = scode_q;
        bus.alu_acode    = acode_q;
        flag_z           = z_q;
        flag_c           = c_q;
        halted           = (state_q == S_HALT);
        illegal          = illegal_q;
        dbg_data         = rf_q[dbg_sel];
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instruction memory with programmable ack delay plus a reference ALU.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  dbg_sel = 3'd0;
    logic [7:0]  dbg_data;
    logic        flag_z, flag_c, halted, illegal;
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    logic [15:0] mem [256];
    logic [8:0]  alu_t;
    logic [15:0] shr_t;

    alu_sequencer_if bus();

    alu_sequencer #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Non-ack cycles present a HALT word so a premature IR load would be visible
    always_comb begin
        bus.imem_ack  = (bus.imem_req && (wait_cnt >= ack_delay)) || force_ack;
        bus.imem_data = bus.imem_ack ? mem[bus.imem_addr] : 16'hF000;
    end

    always_ff @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always_comb begin
        alu_t = '0;
        shr_t = '0;
        if (bus.alu_is_shift) begin
            case (bus.alu_scode)
                2'b00: alu_t = {1'b0, bus.alu_a} << bus.alu_b[2:0];
                2'b01: begin
                    shr_t = {bus.alu_a, 8'h00} >> bus.alu_b[2:0];
                    alu_t = {shr_t[7], shr_t[15:8]};
                end
                default: alu_t = {1'b0, bus.alu_a};
            endcase
        end else begin
            case (bus.alu_acode)
                3'd0: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                3'd1: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'b0, bus.alu_carry_in};
                3'd2: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                3'd3: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'b0, bus.alu_carry_in};
                3'd4: alu_t = {1'b0, bus.alu_a & bus.alu_b};
                3'd5: alu_t = {1'b0, bus.alu_a | bus.alu_b};
                3'd6: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
                default: alu_t = '0;
            endcase
        end
        bus.alu_r         = alu_t[7:0];
        bus.alu_carry_out = alu_t[8];
        bus.alu_zero      = (alu_t[7:0] == 8'h00);
    end

    function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] imm);
        return {4'hC, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction
    function automatic logic [15:0] enc_sh(input logic [1:0] sc, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] imm3);
        return {2'b10, sc, rd, rs, 3'b000, imm3};
    endfunction
    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [7:0] tgt);
        return {op, 4'h0, tgt};
    endfunction

    task automatic start_reset();
        rst_n = 1'b0;
        ack_delay = 0;
        force_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start_reset();
        mem[0] = enc_li(3'd1, 8'h7F);
        mem[1] = enc_li(3'd2, 8'h01);
        mem[2] = enc_r(4'b0000, 3'd3, 3'd1, 3'd2);
        mem[3] = enc_li(3'd0, 8'hFF);
        mem[4] = 16'hF000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd3; #1;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        checks++; if ({halted, illegal, flag_z, flag_c} !== 4'b0000) begin failures++; $display("FAIL reset_status: got %b want 0000", {halted, illegal, flag_z, flag_c}); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_is_shift, bus.alu_scode, bus.alu_acode} !== 23'h0) begin
            failures++; $display("FAIL reset_alu: got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_is_shift, bus.alu_scode, bus.alu_acode}); end
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h want 00", bus.imem_addr); end
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL reset_r3: got %h want 00", dbg_data); end
        rst_n = 1'b1; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            failures++; $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=00", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_basic();
        repeat (9) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd3; #1;
        checks++; if (dbg_data !== 8'h80) begin failures++; $display("FAIL add_r3: got %h want 80", dbg_data); end
        checks++; if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL add_flags: got zc=%b want 00", {flag_z, flag_c}); end
        checks++; if (bus.imem_addr !== 8'h03 || bus.imem_req !== 1'b1) begin
            failures++; $display("FAIL add_pc: got addr=%h req=%b want 03/1", bus.imem_addr, bus.imem_req); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd0; #1;
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL r0_write: got %h want 00", dbg_data); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL halt_op: got halted=%b req=%b want 1/0", halted, bus.imem_req); end
    endtask

    task automatic test_jumps();
        start_reset();
        mem[0]     = enc_li(3'd1, 8'h80);
        mem[1]     = enc_r(4'b0000, 3'd4, 3'd1, 3'd1);
        mem[2]     = enc_j(4'hE, 8'h40);
        mem[8'h40] = enc_r(4'b0100, 3'd5, 3'd1, 3'd0);
        mem[8'h41] = enc_j(4'hD, 8'h50);
        mem[8'h50] = 16'hF000;
        release_reset();
        repeat (9) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd4; #1;
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL add_ovf_r4: got %h want 00", dbg_data); end
        checks++; if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL add_ovf_flags: got zc=%b want 11", {flag_z, flag_c}); end
        checks++; if (bus.imem_addr !== 8'h40) begin failures++; $display("FAIL jc_taken: got %h want 40", bus.imem_addr); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd5; #1;
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL and_r5: got %h want 00", dbg_data); end
        checks++; if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL and_flags: got zc=%b want 11", {flag_z, flag_c}); end
        checks++; if (bus.imem_addr !== 8'h50) begin failures++; $display("FAIL jz_taken: got %h want 50", bus.imem_addr); end
    endtask

    task automatic test_pc_wrap();
        start_reset();
        mem[0]     = enc_li(3'd1, 8'h80);
        mem[1]     = enc_r(4'b0000, 3'd4, 3'd1, 3'd1);
        mem[2]     = enc_j(4'hD, 8'hFF);
        mem[8'hFF] = enc_li(3'd7, 8'h11);
        release_reset();
        repeat (12) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd7; #1;
        checks++; if (dbg_data !== 8'h11) begin failures++; $display("FAIL li_at_ff: got %h want 11", dbg_data); end
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL pc_wrap: got %h want 00", bus.imem_addr); end
    endtask

    task automatic test_shift_zero();
        start_reset();
        mem[0] = enc_li(3'd1, 8'h80);
        mem[1] = enc_r(4'b0000, 3'd4, 3'd1, 3'd1);
        mem[2] = enc_li(3'd1, 8'h5A);
        mem[3] = enc_sh(2'b00, 3'd2, 3'd1, 3'd0);
        mem[4] = enc_sh(2'b00, 3'd6, 3'd1, 3'd1);
        mem[5] = enc_j(4'hE, 8'h20);
        mem[6] = 16'hF000;
        release_reset();
        repeat (11) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.alu_is_shift !== 1'b1 || bus.alu_b !== 8'h00 || bus.alu_a !== 8'h5A || bus.alu_carry_in !== 1'b1) begin
            failures++; $display("FAIL shl0_ctrl: got shift=%b a=%h b=%h cin=%b want 1/5a/00/1", bus.alu_is_shift, bus.alu_a, bus.alu_b, bus.alu_carry_in); end
        @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd2; #1;
        checks++; if (dbg_data !== 8'h5A) begin failures++; $display("FAIL shl0_r2: got %h want 5a", dbg_data); end
        checks++; if ({flag_z, flag_c} !== 2'b01) begin failures++; $display("FAIL shl0_flags: got zc=%b want 01", {flag_z, flag_c}); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        dbg_sel = 3'd6; #1;
        checks++; if (dbg_data !== 8'hB4) begin failures++; $display("FAIL shl1_r6: got %h want b4", dbg_data); end
        checks++; if (flag_c !== 1'b0) begin failures++; $display("FAIL shl1_carry: got %b want 0", flag_c); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.imem_addr !== 8'h06) begin failures++; $display("FAIL jc_not_taken: got %h want 06", bus.imem_addr); end
    endtask

    task automatic test_ack_wait();
        start_reset();
        ack_delay = 3;
        mem[0] = enc_li(3'd1, 8'h33);
        mem[1] = 16'hF000;
        release_reset();
        dbg_sel = 3'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || dbg_data !== 8'h00) begin
                failures++; $display("FAIL ack_wait_hold[%0d]: got req=%b addr=%h r1=%h want 1/00/00", i, bus.imem_req, bus.imem_addr, dbg_data); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.imem_req !== 1'b0 || halted !== 1'b0) begin
            failures++; $display("FAIL ack_wait_decode: got req=%b halted=%b want 0/0", bus.imem_req, halted); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (dbg_data !== 8'h33 || halted !== 1'b0 || bus.imem_addr !== 8'h01) begin
            failures++; $display("FAIL ack_wait_commit: got r1=%h halted=%b addr=%h want 33/0/01", dbg_data, halted, bus.imem_addr); end
    endtask

    task automatic test_illegal();
        start_reset();
        mem[0] = 16'h7000;
        mem[1] = enc_li(3'd1, 8'h22);
        release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_is_shift, bus.alu_scode, bus.alu_acode} !== 23'h0) begin
            failures++; $display("FAIL illegal_alu: got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_is_shift, bus.alu_scode, bus.alu_acode}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if ({illegal, halted, bus.imem_req} !== 3'b110 || bus.imem_addr !== 8'h00) begin
            failures++; $display("FAIL illegal_halt: got ill/halt/req=%b addr=%h want 110/00", {illegal, halted, bus.imem_req}, bus.imem_addr); end
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        dbg_sel = 3'd1; #1;
        checks++; if ({illegal, halted, bus.imem_req} !== 3'b110 || bus.imem_addr !== 8'h00 || dbg_data !== 8'h00) begin
            failures++; $display("FAIL halt_ignores_ack: got ill/halt/req=%b addr=%h r1=%h want 110/00/00", {illegal, halted, bus.imem_req}, bus.imem_addr, dbg_data); end
    endtask

    task automatic test_reset_mid_exec();
        start_reset();
        mem[0] = enc_li(3'd1, 8'h7F);
        mem[1] = enc_li(3'd2, 8'h01);
        mem[2] = enc_r(4'b0000, 3'd3, 3'd1, 3'd2);
        mem[3] = 16'hF000;
        release_reset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.alu_a !== 8'h7F || bus.alu_b !== 8'h01) begin
            failures++; $display("FAIL mid_exec_ops: got a=%h b=%h want 7f/01", bus.alu_a, bus.alu_b); end
        rst_n = 1'b0;
        dbg_sel = 3'd1; #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.alu_a !== 8'h00 || dbg_data !== 8'h00 || bus.imem_addr !== 8'h00) begin
            failures++; $display("FAIL async_reset: got req=%b a=%h r1=%h addr=%h want 0/00/00/00", bus.imem_req, bus.alu_a, dbg_data, bus.imem_addr); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dbg_sel = 3'd3; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || dbg_data !== 8'h00) begin
            failures++; $display("FAIL refetch: got req=%b addr=%h r3=%h want 1/00/00", bus.imem_req, bus.imem_addr, dbg_data); end
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (dbg_data !== 8'h80) begin failures++; $display("FAIL rerun_r3: got %h want 80", dbg_data); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_jumps();
        test_pc_wrap();
        test_shift_zero();
        test_ack_wait();
        test_illegal();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
